// File: rtl/fp_subtractor_if.sv
// Operand/result handshake bundle for the single-precision subtractor.
// The master drives operands and accepts results; the slave is the datapath.
interface fp_subtractor_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] res;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a, b, in_valid, out_ready,
        input  in_ready, res, out_valid
    );

    modport slave (
        input  a, b, in_valid, out_ready,
        output in_ready, res, out_valid
    );
endinterface

// File: rtl/fp_subtractor.sv
// Multi-cycle IEEE-754 single-precision a - b with round-to-nearest-even.
// Denormal inputs read as zero; fixed latency regardless of operand class.
module fp_subtractor (
    input  logic              clk,
    input  logic              rst,
    fp_subtractor_if.slave    bus
);

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic               sub_q, sub_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [27:0]        mag_q, mag_d;
    logic [26:0]        sm_q, sm_d;
    logic               spec_q, spec_d;
    logic [31:0]        spec_val_q, spec_val_d;
    logic [31:0]        res_q, res_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
    logic               bn_sign, swap, l_sign;
    logic [30:0]        a_key, b_key;
    logic [23:0]        sig_a, sig_b, l_sig, s_sig;
    logic [7:0]         l_exp, s_exp, shift_amt;
    logic [49:0]        wide;
    logic [26:0]        aligned;
    logic               al_spec;
    logic [31:0]        al_spec_val;

    logic [4:0]         lz;
    logic [26:0]        norm_sig;
    logic signed [9:0]  norm_exp;

    logic               rnd_inc;
    logic [24:0]        mant;
    logic signed [9:0]  rnd_exp;
    logic [22:0]        rnd_frac;
    logic [31:0]        rnd_res;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd27;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(26 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign a_zero  = (a_q[30:23] == 8'h00);
    assign b_zero  = (b_q[30:23] == 8'h00);
    assign a_nan   = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
    assign b_nan   = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
    assign a_inf   = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
    assign b_inf   = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    assign bn_sign = ~b_q[31];

    // Denormal fractions are masked so they compare and behave as zero.
    assign a_key = {a_q[30:23], a_zero ? 23'd0 : a_q[22:0]};
    assign b_key = {b_q[30:23], b_zero ? 23'd0 : b_q[22:0]};
    assign sig_a = a_zero ? 24'd0 : {1'b1, a_q[22:0]};
    assign sig_b = b_zero ? 24'd0 : {1'b1, b_q[22:0]};
    assign swap  = (b_key > a_key);

    assign l_sign    = swap ? bn_sign : a_q[31];
    assign l_exp     = swap ? b_q[30:23] : a_q[30:23];
    assign s_exp     = swap ? a_q[30:23] : b_q[30:23];
    assign l_sig     = swap ? sig_b : sig_a;
    assign s_sig     = swap ? sig_a : sig_b;
    assign shift_amt = l_exp - s_exp;
    assign wide      = {s_sig, 26'd0} >> shift_amt;
    assign aligned   = (shift_amt >= 8'd26) ? 27'd0 : {wide[49:24], |wide[23:0]};

    always_comb begin
        al_spec     = 1'b1;
        al_spec_val = 32'h7FC00000;
        if (a_nan || b_nan) begin
            al_spec_val = 32'h7FC00000;
        end else if (a_inf && b_inf) begin
            al_spec_val = (a_q[31] == b_q[31]) ? 32'h7FC00000 : a_q;
        end else if (a_inf) begin
            al_spec_val = a_q;
        end else if (b_inf) begin
            al_spec_val = {bn_sign, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            al_spec_val = {a_q[31] & bn_sign, 31'd0};
        end else begin
            al_spec = 1'b0;
        end
    end

    assign lz = lzc27(mag_q[26:0]);

    always_comb begin
        norm_sig = mag_q[26:0] << lz;
        norm_exp = exp_q - $signed({5'd0, lz});
        if (mag_q[27]) begin
            norm_sig = {mag_q[27:2], mag_q[1] | mag_q[0]};
            norm_exp = exp_q + 10'sd1;
        end
    end

    // A zero hidden bit after rounding can only mean an exact cancellation.
    assign rnd_inc  = mag_q[2] & (mag_q[1] | mag_q[0] | mag_q[3]);
    assign mant     = {1'b0, mag_q[26:3]} + {24'd0, rnd_inc};
    assign rnd_exp  = exp_q + (mant[24] ? 10'sd1 : 10'sd0);
    assign rnd_frac = mant[24] ? 23'd0 : mant[22:0];

    always_comb begin
        if (spec_q) begin
            rnd_res = spec_val_q;
        end else if (!(mant[24] | mant[23])) begin
            rnd_res = 32'h00000000;
        end else if (rnd_exp <= 10'sd0) begin
            rnd_res = {sign_q, 31'd0};
        end else if (rnd_exp >= 10'sd255) begin
            rnd_res = {sign_q, 8'hFF, 23'd0};
        end else begin
            rnd_res = {sign_q, rnd_exp[7:0], rnd_frac};
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        exp_d      = exp_q;
        mag_d      = mag_q;
        sm_d       = sm_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        res_d      = res_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                sign_d     = l_sign;
                sub_d      = a_q[31] ^ bn_sign;
                exp_d      = {2'b00, l_exp};
                mag_d      = {1'b0, l_sig, 3'b000};
                sm_d       = aligned;
                spec_d     = al_spec;
                spec_val_d = al_spec_val;
                state_d    = ADD;
            end
            ADD: begin
                mag_d   = sub_q ? (mag_q - {1'b0, sm_q}) : (mag_q + {1'b0, sm_q});
                state_d = NORM;
            end
            NORM: begin
                mag_d   = {1'b0, norm_sig};
                exp_d   = norm_exp;
                state_d = ROUND;
            end
            ROUND: begin
                res_d   = rnd_res;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            sub_q       <= 1'b0;
            exp_q       <= '0;
            mag_q       <= '0;
            sm_q        <= '0;
            spec_q      <= 1'b0;
            spec_val_q  <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sign_q      <= sign_d;
            sub_q       <= sub_d;
            exp_q       <= exp_d;
            mag_q       <= mag_d;
            sm_q        <= sm_d;
            spec_q      <= spec_d;
            spec_val_q  <= spec_val_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.res       = res_q;

endmodule

// File: tb/tb_fp_subtractor.sv
// Directed-vector bench for fp_subtractor: results, handshake timing,
// output hold under back-pressure and reset abort.
module tb_fp_subtractor;

    logic clk;
    logic rst;
    int   checkCount;
    int   errorCount;

    fp_subtractor_if bus();

    fp_subtractor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic applyStimulus(input string tag, input logic [31:0] aIn, input logic [31:0] bIn,
                                 input logic [31:0] expRes, input int holdCycles);
        checkOutput({tag, "/idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.a         = aIn;
        bus.b         = bIn;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = 32'hDEADBEEF;
        bus.b        = 32'hDEADBEEF;
        checkOutput({tag, "/busy"}, {31'd0, bus.in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput({tag, "/early_valid"}, {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        checkOutput({tag, "/valid"}, {31'd0, bus.out_valid}, 32'd1);
        checkOutput({tag, "/res"}, bus.res, expRes);
        for (int i = 0; i < holdCycles; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 32'h12345678;
            bus.b        = 32'h3F800000;
            @(negedge clk);
            checkOutput({tag, "/hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            checkOutput({tag, "/hold_res"}, bus.res, expRes);
            checkOutput({tag, "/hold_ready"}, {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "/released"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        checkCount    = 0;
        errorCount    = 0;
        rst           = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset/ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("reset/valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset/res", bus.res, 32'h00000000);
        rst = 1'b0;

        applyStimulus("3-1",        32'h40400000, 32'h3F800000, 32'h40000000, 3);
        applyStimulus("1-ulp",      32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 0);
        applyStimulus("tie_even",   32'h3F800000, 32'hB3800000, 32'h3F800000, 0);
        applyStimulus("round_up",   32'h3F800000, 32'hB3C00000, 32'h3F800001, 0);
        applyStimulus("round_ovf",  32'h3FFFFFFF, 32'hB3800000, 32'h40000000, 0);
        applyStimulus("carry",      32'h3F800000, 32'hBF800000, 32'h40000000, 0);
        applyStimulus("neg_res",    32'h3F800000, 32'h40000000, 32'hBF800000, 0);
        applyStimulus("cancel",     32'h3F800000, 32'h3F800000, 32'h00000000, 0);
        applyStimulus("nz-z",       32'h80000000, 32'h00000000, 32'h80000000, 0);
        applyStimulus("z-z",        32'h00000000, 32'h00000000, 32'h00000000, 0);
        applyStimulus("denorm",     32'h00000001, 32'h3F800000, 32'hBF800000, 0);
        applyStimulus("underflow",  32'h00800000, 32'h00C00000, 32'h80000000, 0);
        applyStimulus("overflow",   32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 0);
        applyStimulus("inf-inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 0);
        applyStimulus("inf+inf",    32'h7F800000, 32'hFF800000, 32'h7F800000, 0);
        applyStimulus("nan",        32'h7F800001, 32'h3F800000, 32'h7FC00000, 0);
        applyStimulus("ninf-fin",   32'hFF800000, 32'h3F800000, 32'hFF800000, 0);
        applyStimulus("fin-inf",    32'h3F800000, 32'h7F800000, 32'hFF800000, 0);
        applyStimulus("fin-ninf",   32'h3F800000, 32'hFF800000, 32'h7F800000, 0);

        // Abort during NORM with in_valid held alongside reset.
        bus.a        = 32'h40400000;
        bus.b        = 32'h3F800000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        checkOutput("rst_norm/ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_norm/valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_norm/res", bus.res, 32'h00000000);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("rst_norm/no_stale", {31'd0, bus.out_valid}, 32'd0);
            checkOutput("rst_norm/still_idle", {31'd0, bus.in_ready}, 32'd1);
        end

        // Abort while a result waits in DONE.
        bus.a        = 32'h3F800000;
        bus.b        = 32'hBF800000;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("rst_done/valid_before", {31'd0, bus.out_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_done/valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_done/res", bus.res, 32'h00000000);
        checkOutput("rst_done/ready", {31'd0, bus.in_ready}, 32'd1);

        applyStimulus("after_rst",  32'h40400000, 32'h3F800000, 32'h40000000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
